// File: rtl/vga_mem_arbiter.sv
// vga_mem_arbiter: shares one synchronous tile RAM between the VGA scan-out
// reader and a game-logic writer; display reads always win their slot.
module vga_mem_arbiter #(
    parameter int VBLANK_ONLY = 0,
    parameter int COLS        = 80
) (
    input  logic        clk,
    input  logic        rst,
    output logic        pixel_en,
    input  logic [9:0]  h_count,
    input  logic [9:0]  v_count,
    input  logic        h_valid,
    input  logic        v_valid,
    input  logic        wr_req,
    input  logic [12:0] wr_addr,
    input  logic [7:0]  wr_data,
    output logic        wr_ack,
    output logic [12:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  pixel_color,
    output logic        frame_start
);

    typedef enum logic [1:0] {
        W_IDLE,
        W_ISSUE,
        W_ACK
    } wstate_t;

    wstate_t     state;
    logic        started;
    logic        active;
    logic        read_slot;
    logic        vb_ok;
    logic        issue_go;
    logic        rd_d;
    logic        blank_d;
    logic [12:0] disp_addr;
    logic        unused_bits;

    assign unused_bits = ^{v_count[9], v_count[2:0], h_count[2:0]};

    assign active    = h_valid & v_valid;
    assign read_slot = pixel_en & active;
    assign disp_addr = 13'(v_count[8:3]) * 13'(COLS) + 13'(h_count[9:3]);
    assign vb_ok     = (VBLANK_ONLY == 0) || !v_valid;

    // Deciding in a pixel_en=1 cycle puts W_ISSUE on the following
    // pixel_en=0 cycle, which can never be a read slot.
    assign issue_go = wr_req & pixel_en & vb_ok;

    // Pixel-clock enable: one idle edge after reset, then toggle forever.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            started  <= 1'b0;
            pixel_en <= 1'b0;
        end else if (!started) begin
            started  <= 1'b1;
        end else begin
            pixel_en <= ~pixel_en;
        end
    end

    // Writer FSM with registered one-cycle acknowledge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= W_IDLE;
            wr_ack <= 1'b0;
        end else begin
            wr_ack <= (state == W_ISSUE);
            case (state)
                W_IDLE:  if (issue_go) state <= W_ISSUE;
                W_ISSUE: state <= W_ACK;
                W_ACK:   state <= W_IDLE;
                default: state <= W_IDLE;
            endcase
        end
    end

    // RAM port mux: the writer owns the port only in W_ISSUE.
    always_comb begin
        mem_addr  = disp_addr;
        mem_we    = 1'b0;
        mem_wdata = 8'h00;
        if (state == W_ISSUE) begin
            mem_addr  = wr_addr;
            mem_we    = 1'b1;
            mem_wdata = wr_data;
        end
    end

    // Colour register: RAM data lands one cycle after the read slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_d        <= 1'b0;
            blank_d     <= 1'b0;
            pixel_color <= 8'h00;
        end else begin
            rd_d    <= read_slot;
            blank_d <= pixel_en & ~active;
            if (rd_d) begin
                pixel_color <= mem_rdata;
            end else if (blank_d) begin
                pixel_color <= 8'h00;
            end
        end
    end

    // Frame marker at the pixel that sits on the top-left origin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= pixel_en && (h_count == 10'd0) && (v_count == 10'd0);
        end
    end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// tb_vga_mem_arbiter: directed scenarios plus a randomized run against a
// cycle-level reference model of the arbiter's slot and write rules.
module tb_vga_mem_arbiter;

    localparam int COLS = 80;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pixel_en, pixel_en2;
    logic [9:0]  h_count, v_count;
    logic        h_valid, v_valid;
    logic        wr_req, wr_req2;
    logic [12:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ack, wr_ack2;
    logic [12:0] mem_addr, mem_addr2;
    logic        mem_we, mem_we2;
    logic [7:0]  mem_wdata, mem_wdata2;
    logic [7:0]  mem_rdata;
    logic [7:0]  mem_rdata2;
    logic [7:0]  pixel_color, pixel_color2;
    logic        frame_start, frame_start2;

    int checks = 0;
    int errors = 0;
    int n;

    logic [7:0]  ram [8192];
    logic        fill;
    logic        pre_we;
    logic [12:0] pre_addr;
    logic [7:0]  pre_data;
    logic [7:0]  seed;
    logic [7:0]  wmap [int];

    always #5 clk = ~clk;

    vga_mem_arbiter #(.VBLANK_ONLY(0), .COLS(COLS)) dut (
        .clk(clk), .rst(rst), .pixel_en(pixel_en),
        .h_count(h_count), .v_count(v_count),
        .h_valid(h_valid), .v_valid(v_valid),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .pixel_color(pixel_color), .frame_start(frame_start)
    );

    vga_mem_arbiter #(.VBLANK_ONLY(1), .COLS(COLS)) dut2 (
        .clk(clk), .rst(rst), .pixel_en(pixel_en2),
        .h_count(h_count), .v_count(v_count),
        .h_valid(h_valid), .v_valid(v_valid),
        .wr_req(wr_req2), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack2), .mem_addr(mem_addr2), .mem_we(mem_we2),
        .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2),
        .pixel_color(pixel_color2), .frame_start(frame_start2)
    );

    assign mem_rdata2 = 8'h00;

    function automatic logic [7:0] fill_val(int i);
        return 8'((i * 7) ^ (i >> 5)) ^ seed;
    endfunction

    // Synchronous tile RAM shared by the main DUT and bench preloads.
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 8192; i++) ram[i] <= fill_val(i);
        end else if (pre_we) begin
            ram[pre_addr] <= pre_data;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    function automatic logic [7:0] ref_rd(int a);
        if (wmap.exists(a)) return wmap[a];
        return fill_val(a);
    endfunction

    function automatic int disp(logic [9:0] h, logic [9:0] v);
        return ((int'(v >> 3) % 64) * COLS + int'(h >> 3)) % 8192;
    endfunction

    function automatic logic pe_model(int k);
        return (k >= 2) && (k % 2 == 0);
    endfunction

    function automatic int next_pe0(int t);
        int c = t + 1;
        while (pe_model(c)) c++;
        return c;
    endfunction

    task automatic hold_reset();
        rst = 1'b1;
        wr_req = 1'b0; wr_req2 = 1'b0;
        h_valid = 1'b0; v_valid = 1'b0;
        h_count = '0; v_count = '0;
        wr_addr = '0; wr_data = '0;
        pre_we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic release_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        n = 0;
    endtask

    task automatic poke(int a, logic [7:0] d);
        pre_addr = 13'(a); pre_data = d; pre_we = 1'b1;
        @(posedge clk); #1;
        pre_we = 1'b0;
        wmap[a] = d;
    endtask

    task automatic next();
        @(posedge clk); #1;
        n++;
    endtask

    task automatic test_reset();
        hold_reset();
        wr_req = 1'b1; wr_addr = 13'd5; wr_data = 8'h11;
        h_valid = 1'b1; v_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({pixel_en, wr_ack, frame_start, mem_we, pixel_color} !== 12'h0) begin
            errors++;
            $display("FAIL rst_outputs got pe=%0b ack=%0b fs=%0b we=%0b pc=%0h want all 0",
                     pixel_en, wr_ack, frame_start, mem_we, pixel_color);
        end
        wr_req = 1'b0; h_valid = 1'b0; v_valid = 1'b0;
        h_count = 10'd5; v_count = 10'd5;
        release_reset();
        for (int k = 1; k <= 4; k++) begin
            next();
            @(negedge clk);
            checks++;
            if (pixel_en !== pe_model(n)) begin
                errors++;
                $display("FAIL rst_pe_seq edge=%0d got %0b want %0b", n, pixel_en, pe_model(n));
            end
            if (n == 1) begin
                checks++;
                if ({wr_ack, frame_start, mem_we, pixel_color} !== 11'h0) begin
                    errors++;
                    $display("FAIL rst_first_edge got ack=%0b fs=%0b we=%0b pc=%0h want 0",
                             wr_ack, frame_start, mem_we, pixel_color);
                end
            end
        end
    endtask

    task automatic test_read();
        hold_reset();
        poke(82, 8'h5A);
        h_count = 10'd16; v_count = 10'd8;
        h_valid = 1'b1; v_valid = 1'b1;
        release_reset();
        for (int k = 1; k <= 4; k++) begin
            next();
            @(negedge clk);
            if (pe_model(n)) begin
                checks++;
                if (mem_addr !== 13'(disp(10'd16, 10'd8)) || mem_we !== 1'b0) begin
                    errors++;
                    $display("FAIL read_slot got addr=%0d we=%0b want addr=%0d we=0",
                             mem_addr, mem_we, disp(10'd16, 10'd8));
                end
            end
            if (n == 3) begin
                checks++;
                if (pixel_color !== 8'h00) begin
                    errors++;
                    $display("FAIL read_early got %0h want 0", pixel_color);
                end
            end
            if (n == 4) begin
                checks++;
                if (pixel_color !== ref_rd(82)) begin
                    errors++;
                    $display("FAIL read_color got %0h want %0h", pixel_color, ref_rd(82));
                end
            end
        end
    endtask

    task automatic test_write_active();
        int t0 = 3, we_n = -1, ack_n = -1, wes = 0, acks = 0, c;
        logic acked = 1'b0;
        hold_reset();
        h_count = 10'd16; v_count = 10'd8;
        h_valid = 1'b1; v_valid = 1'b1;
        release_reset();
        for (int k = 1; k <= 12; k++) begin
            next();
            if (n == t0) begin
                wr_req = 1'b1; wr_addr = 13'd100; wr_data = 8'h33;
            end
            if (acked) wr_req = 1'b0;
            @(negedge clk);
            if (mem_we) begin
                we_n = n; wes++;
                checks++;
                if (mem_addr !== 13'd100 || mem_wdata !== 8'h33 || pe_model(n)) begin
                    errors++;
                    $display("FAIL wr_issue got addr=%0d data=%0h pe=%0b want 100/33/0",
                             mem_addr, mem_wdata, pe_model(n));
                end
            end
            if (wr_ack) begin
                ack_n = n; acks++; acked = 1'b1;
            end
        end
        c = next_pe0(t0);
        checks++;
        if (we_n != c || wes != 1) begin
            errors++;
            $display("FAIL wr_we_cycle got %0d (count %0d) want %0d (count 1)", we_n, wes, c);
        end
        checks++;
        if (ack_n != c + 1 || acks != 1 || ack_n - t0 > 3) begin
            errors++;
            $display("FAIL wr_ack_cycle got %0d (count %0d) want %0d (count 1)", ack_n, acks, c + 1);
        end
        if (acks == 1) wmap[100] = 8'h33;
        checks++;
        if (ram[100] !== 8'h33) begin
            errors++;
            $display("FAIL wr_ram got %0h want 33", ram[100]);
        end
    endtask

    task automatic test_vblank_only();
        int req = 2, drop = 10, we_n = -1, ack_n = -1, wes = 0, c;
        logic vv_hist [32];
        logic acked = 1'b0;
        hold_reset();
        h_count = 10'd16; v_count = 10'd8;
        h_valid = 1'b1; v_valid = 1'b1;
        release_reset();
        for (int k = 1; k <= 16; k++) begin
            next();
            if (n == req) begin
                wr_req2 = 1'b1; wr_addr = 13'd200; wr_data = 8'h77;
            end
            if (n == drop) v_valid = 1'b0;
            if (acked) wr_req2 = 1'b0;
            vv_hist[n] = v_valid;
            @(negedge clk);
            if (mem_we2) begin
                we_n = n; wes++;
                checks++;
                if (mem_addr2 !== 13'd200 || mem_wdata2 !== 8'h77) begin
                    errors++;
                    $display("FAIL vb_issue got addr=%0d data=%0h want 200/77", mem_addr2, mem_wdata2);
                end
            end
            if (wr_ack2) begin
                ack_n = n; acked = 1'b1;
            end
        end
        c = req + 1;
        while (pe_model(c) || vv_hist[c - 1]) c++;
        checks++;
        if (we_n != c || wes != 1) begin
            errors++;
            $display("FAIL vb_we_cycle got %0d (count %0d) want %0d (count 1)", we_n, wes, c);
        end
        checks++;
        if (ack_n != c + 1) begin
            errors++;
            $display("FAIL vb_ack_cycle got %0d want %0d", ack_n, c + 1);
        end
    endtask

    task automatic test_blank_frame();
        hold_reset();
        poke(82, 8'hA5);
        h_count = 10'd16; v_count = 10'd8;
        h_valid = 1'b1; v_valid = 1'b1;
        release_reset();
        for (int k = 1; k <= 8; k++) begin
            next();
            if (n == 4) h_valid = 1'b0;
            if (n == 6) begin h_count = 10'd0; v_count = 10'd0; end
            if (n == 7) h_count = 10'd1;
            @(negedge clk);
            if (n == 4 || n == 5) begin
                checks++;
                if (pixel_color !== ref_rd(82)) begin
                    errors++;
                    $display("FAIL blank_hold n=%0d got %0h want %0h", n, pixel_color, ref_rd(82));
                end
            end
            if (n == 6) begin
                checks++;
                if (pixel_color !== 8'h00) begin
                    errors++;
                    $display("FAIL blank_zero got %0h want 0", pixel_color);
                end
            end
            if (n >= 6) begin
                checks++;
                if (frame_start !== (n == 7)) begin
                    errors++;
                    $display("FAIL frame_pulse n=%0d got %0b want %0b", n, frame_start, n == 7);
                end
            end
        end
    endtask

    task automatic test_reset_mid_write();
        hold_reset();
        h_count = 10'd16; v_count = 10'd8;
        h_valid = 1'b1; v_valid = 1'b1;
        release_reset();
        for (int k = 1; k <= 5; k++) begin
            next();
            if (n == 3) begin
                wr_req = 1'b1; wr_addr = 13'd300; wr_data = 8'h44;
            end
            @(negedge clk);
        end
        checks++;
        if (mem_we !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre got we=%0b want 1", mem_we);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (mem_we !== 1'b0) begin
            errors++;
            $display("FAIL midrst_we got %0b want 0", mem_we);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if (wr_ack !== 1'b0 || mem_we !== 1'b0) begin
                errors++;
                $display("FAIL midrst_hold got ack=%0b we=%0b want 0/0", wr_ack, mem_we);
            end
        end
        wr_req = 1'b0;
        release_reset();
        for (int k = 1; k <= 6; k++) begin
            next();
            @(negedge clk);
            checks++;
            if (wr_ack !== 1'b0 || mem_we !== 1'b0) begin
                errors++;
                $display("FAIL midrst_after n=%0d got ack=%0b we=%0b want 0/0", n, wr_ack, mem_we);
            end
        end
        checks++;
        if (ram[300] !== ref_rd(300)) begin
            errors++;
            $display("FAIL midrst_ram got %0h want %0h", ram[300], ref_rd(300));
        end
    endtask

    task automatic test_random();
        logic outstanding = 1'b0, drop = 1'b0;
        int exp_issue = 0, d;
        logic pe, act, exp_we, exp_ack, fs_exp = 1'b0;
        logic p1_v = 1'b0, p2_v = 1'b0;
        logic [7:0] p1_val = '0, p2_val = '0, exp_color = '0;
        hold_reset();
        release_reset();
        for (int k = 1; k <= 3000; k++) begin
            next();
            if (drop) begin wr_req = 1'b0; drop = 1'b0; end
            if ($urandom_range(0, 15) == 0) begin
                h_count = 10'd0; v_count = 10'd0;
            end else begin
                h_count = 10'($urandom_range(0, 1023));
                v_count = 10'($urandom_range(0, 1023));
            end
            h_valid = ($urandom_range(0, 3) != 0);
            v_valid = ($urandom_range(0, 3) != 0);
            if (!outstanding && !wr_req && n >= 2 && $urandom_range(0, 3) == 0) begin
                wr_req = 1'b1;
                wr_addr = 13'($urandom_range(6000, 8191));
                wr_data = 8'($urandom);
                outstanding = 1'b1;
                exp_issue = next_pe0(n);
            end
            @(negedge clk);
            pe = pe_model(n);
            act = h_valid && v_valid;
            d = disp(h_count, v_count);
            checks++;
            if (pixel_en !== pe) begin
                errors++;
                $display("FAIL rnd_pe n=%0d got %0b want %0b", n, pixel_en, pe);
            end
            checks++;
            if (frame_start !== fs_exp) begin
                errors++;
                $display("FAIL rnd_frame n=%0d got %0b want %0b", n, frame_start, fs_exp);
            end
            fs_exp = pe && h_count == 0 && v_count == 0;
            if (p2_v) exp_color = p2_val;
            checks++;
            if (pixel_color !== exp_color) begin
                errors++;
                $display("FAIL rnd_color n=%0d got %0h want %0h", n, pixel_color, exp_color);
            end
            p2_v = p1_v; p2_val = p1_val;
            p1_v = pe; p1_val = act ? ref_rd(d) : 8'h00;
            exp_we = outstanding && n == exp_issue;
            checks++;
            if (mem_we !== exp_we) begin
                errors++;
                $display("FAIL rnd_we n=%0d got %0b want %0b", n, mem_we, exp_we);
            end
            checks++;
            if (exp_we && (mem_addr !== wr_addr || mem_wdata !== wr_data)) begin
                errors++;
                $display("FAIL rnd_wbus n=%0d got %0d/%0h want %0d/%0h",
                         n, mem_addr, mem_wdata, wr_addr, wr_data);
            end else if (!exp_we && (mem_addr !== 13'(d) || mem_wdata !== 8'h00)) begin
                errors++;
                $display("FAIL rnd_rbus n=%0d got %0d/%0h want %0d/0", n, mem_addr, mem_wdata, d);
            end
            exp_ack = outstanding && n == exp_issue + 1;
            checks++;
            if (wr_ack !== exp_ack) begin
                errors++;
                $display("FAIL rnd_ack n=%0d got %0b want %0b", n, wr_ack, exp_ack);
            end
            if (exp_ack) begin
                wmap[int'(wr_addr)] = wr_data;
                outstanding = 1'b0;
                drop = 1'b1;
            end
        end
        next();
        wr_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        foreach (wmap[a]) begin
            if (a >= 6000) begin
                checks++;
                if (ram[a] !== wmap[a]) begin
                    errors++;
                    $display("FAIL rnd_ram addr=%0d got %0h want %0h", a, ram[a], wmap[a]);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        fill = 1'b0;
        pre_we = 1'b0;
        pre_addr = '0;
        pre_data = '0;
        seed = 8'($urandom);
        hold_reset();
        fill = 1'b1;
        @(posedge clk); #1;
        fill = 1'b0;
        test_reset();
        test_read();
        test_write_active();
        test_vblank_only();
        test_blank_frame();
        test_reset_mid_write();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
